// File: rtl/n64_rx_decoder.sv
// N64 controller reply receiver: samples the one-wire line, decodes 32 data bits plus stop bit.
// Latency: data_valid one cycle after the stop bit's synchronized rising edge; no backpressure, rx_en ignored while busy.
module n64_rx_decoder #(
  parameter int SAMPLE_CYCLES  = 200,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int NUM_BITS       = 32
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        pin_in,
  input  logic        rx_en,
  output logic [31:0] data_word,
  output logic        data_valid,
  output logic        rx_busy,
  output logic        rx_error,
  output logic [5:0]  bit_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SAMPLE_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [SW-1:0] S_LAST = SW'(SAMPLE_CYCLES - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [5:0]    N_BITS = 6'(NUM_BITS);

  typedef enum logic [2:0] {IDLE, WAIT_FALL, SAMPLE, WAIT_RISE, DONE} state_t;

  state_t         state;
  logic           sync_meta, sync_cur, sync_prev;
  logic           fall;
  logic           stop_seen;
  logic [31:0]    shreg;
  logic [TW-1:0]  tcnt;
  logic [SW-1:0]  scnt;

  // Flops reset high so an idle line never looks like a falling edge.
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      sync_meta <= 1'b1;
      sync_cur  <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync_meta <= pin_in;
      sync_cur  <= sync_meta;
      sync_prev <= sync_cur;
    end
  end

  assign fall = sync_prev & ~sync_cur;

  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      state      <= IDLE;
      data_word  <= 32'd0;
      data_valid <= 1'b0;
      rx_busy    <= 1'b0;
      rx_error   <= 1'b0;
      bit_count  <= 6'd0;
      stop_seen  <= 1'b0;
      shreg      <= 32'd0;
      tcnt       <= '0;
      scnt       <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_en) begin
            rx_error  <= 1'b0;
            bit_count <= 6'd0;
            shreg     <= 32'd0;
            stop_seen <= 1'b0;
            rx_busy   <= 1'b1;
            tcnt      <= '0;
            state     <= WAIT_FALL;
          end
        end
        WAIT_FALL: begin
          if (fall) begin
            scnt  <= '0;
            tcnt  <= '0;
            state <= SAMPLE;
          end else if (tcnt == T_LAST) begin
            rx_error <= 1'b1;
            rx_busy  <= 1'b0;
            state    <= IDLE;
          end else begin
            tcnt <= tcnt + T_ONE;
          end
        end
        SAMPLE: begin
          // Level sample: glitches or early rising edges before this point are irrelevant.
          if (scnt == S_LAST) begin
            if (bit_count < N_BITS) begin
              shreg     <= {shreg[30:0], sync_cur};
              bit_count <= bit_count + 6'd1;
            end else begin
              stop_seen <= 1'b1;
            end
            tcnt  <= '0;
            state <= WAIT_RISE;
          end else begin
            scnt <= scnt + S_ONE;
          end
        end
        WAIT_RISE: begin
          if (sync_cur) begin
            tcnt <= '0;
            if (stop_seen) begin
              data_word  <= shreg;
              data_valid <= 1'b1;
              rx_busy    <= 1'b0;
              state      <= DONE;
            end else begin
              state <= WAIT_FALL;
            end
          end else if (tcnt == T_LAST) begin
            rx_error <= 1'b1;
            rx_busy  <= 1'b0;
            state    <= IDLE;
          end else begin
            tcnt <= tcnt + T_ONE;
          end
        end
        // One-cycle holdoff so an rx_en coinciding with the valid pulse is dropped.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_rx_decoder.sv
// Directed + randomized bench for n64_rx_decoder; reference is a frame-level model of what each reply should yield.
module tb_n64_rx_decoder;

  logic        PCLK = 1'b0;
  logic        PRESERN;
  logic        pin_in;
  logic        rx_en;
  logic [31:0] data_word;
  logic        data_valid;
  logic        rx_busy;
  logic        rx_error;
  logic [5:0]  bit_count;

  n64_rx_decoder dut (
    .PCLK       (PCLK),
    .PRESERN    (PRESERN),
    .pin_in     (pin_in),
    .rx_en      (rx_en),
    .data_word  (data_word),
    .data_valid (data_valid),
    .rx_busy    (rx_busy),
    .rx_error   (rx_error),
    .bit_count  (bit_count)
  );

  always #5 PCLK = ~PCLK;

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;
  int busy_bad = 0;
  logic busy_prev = 1'b0;

  // Reference state: last good frame and number of good frames seen.
  logic [31:0] model_word;
  int          model_valids;
  logic [31:0] w;

  // Every valid pulse must coincide with rx_busy falling.
  always @(negedge PCLK) begin
    if (data_valid === 1'b1) begin
      valid_cnt++;
      if (!(rx_busy === 1'b0 && busy_prev === 1'b1)) busy_bad++;
    end
    busy_prev = rx_busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // '0' = 3/4 period low, '1' = 1/4 period low.
  task automatic send_bit(input logic b, input int per);
    pin_in = 1'b0;
    tick(b ? per / 4 : 3 * per / 4);
    pin_in = 1'b1;
    tick(b ? 3 * per / 4 : per / 4);
  endtask

  task automatic send_frame(input logic [31:0] word, input int nbits, input logic stop, input int per);
    for (int i = 0; i < nbits; i++) send_bit(word[31 - i], per);
    if (stop) send_bit(1'b1, per);
  endtask

  task automatic start_rx();
    tick(1);
    rx_en = 1'b1;
    tick(1);
    rx_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 500; c++) begin
      if (rx_busy === 1'b0) break;
      tick(1);
    end
    check(tag, {31'd0, rx_busy}, 32'd0);
  endtask

  task automatic good_frame(input logic [31:0] word, input int per, input string tag);
    start_rx();
    send_frame(word, 32, 1'b1, per);
    wait_idle({tag, "_idle"});
    model_word = word;
    model_valids++;
    @(negedge PCLK);
    check({tag, "_word"},   data_word, model_word);
    check({tag, "_valids"}, valid_cnt, model_valids);
    check({tag, "_err"},    {31'd0, rx_error}, 32'd0);
    check({tag, "_bits"},   {26'd0, bit_count}, 32'd32);
  endtask

  task automatic check_abort(input string tag, input int bits_exp);
    @(negedge PCLK);
    check({tag, "_err"},    {31'd0, rx_error}, 32'd1);
    check({tag, "_busy"},   {31'd0, rx_busy}, 32'd0);
    check({tag, "_bits"},   {26'd0, bit_count}, bits_exp);
    check({tag, "_word"},   data_word, model_word);
    check({tag, "_valids"}, valid_cnt, model_valids);
  endtask

  initial begin
    model_word   = 32'd0;
    model_valids = 0;
    pin_in  = 1'b1;
    rx_en   = 1'b0;
    PRESERN = 1'b1;
    tick(4);
    @(negedge PCLK);
    check("rst_word",  data_word, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_busy",  {31'd0, rx_busy}, 32'd0);
    check("rst_err",   {31'd0, rx_error}, 32'd0);
    check("rst_bits",  {26'd0, bit_count}, 32'd0);
    PRESERN = 1'b0;

    // Single-one frame at the nominal 400-cycle bit period.
    start_rx();
    @(negedge PCLK);
    check("t1_busy_set", {31'd0, rx_busy}, 32'd1);
    send_frame(32'h8000_0000, 32, 1'b1, 400);
    wait_idle("t1_idle");
    model_word = 32'h8000_0000;
    model_valids++;
    @(negedge PCLK);
    check("t1_word",   data_word, model_word);
    check("t1_valids", valid_cnt, model_valids);
    check("t1_err",    {31'd0, rx_error}, 32'd0);
    check("t1_bits",   {26'd0, bit_count}, 32'd32);
    check("t1_busy_drop", busy_bad, 0);

    good_frame(32'hA5C3_0F7E, 320, "t2a");
    good_frame(32'h0000_0001, 320, "t2b");
    good_frame($urandom, 320, "rand");

    // No reply at all.
    start_rx();
    tick(1100);
    check_abort("t3", 0);
    start_rx();
    @(negedge PCLK);
    check("t3_err_clr", {31'd0, rx_error}, 32'd0);
    check("t3_busy",    {31'd0, rx_busy}, 32'd1);
    tick(1100);

    // Reply stops after 17 bits.
    w = $urandom;
    start_rx();
    send_frame(w, 17, 1'b0, 320);
    tick(1200);
    check_abort("t4", 17);

    // Line stuck low after 5 bits; the stuck-low pulse is itself sampled as a sixth bit.
    w = $urandom;
    start_rx();
    send_frame(w, 5, 1'b0, 320);
    pin_in = 1'b0;
    tick(1500);
    pin_in = 1'b1;
    check_abort("t5", 6);

    // Reset in the middle of bit 10.
    w = $urandom;
    start_rx();
    send_frame(w, 9, 1'b0, 320);
    pin_in = 1'b0;
    tick(50);
    PRESERN = 1'b1;
    tick(1);
    PRESERN = 1'b0;
    model_word = 32'd0;
    @(negedge PCLK);
    check("t6_word",  data_word, 32'd0);
    check("t6_valid", {31'd0, data_valid}, 32'd0);
    check("t6_busy",  {31'd0, rx_busy}, 32'd0);
    check("t6_err",   {31'd0, rx_error}, 32'd0);
    check("t6_bits",  {26'd0, bit_count}, 32'd0);
    pin_in = 1'b1;
    tick(20);
    good_frame(32'hFFFF_FFFF, 320, "t6_after");
    check("final_busy_drop", busy_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
